// File: rtl/instr_fetch_reg.sv
// Instruction-fetch sequencer and Instruction Register for the multi-cycle MIPS datapath.
// Optional build macro FETCH_ERR_NOP_EN: entering ERR loads IR with a NOP (32'h0).
module instr_fetch_reg #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        ir_valid,
    output logic        fetch_err,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm_16,
    output logic [25:0] j_target
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]       state_r,     state_s;
    logic [31:0]      ir_r,        ir_s;
    logic [31:0]      mem_addr_r,  mem_addr_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic             mem_req_r,   mem_req_s;
    logic             busy_r,      busy_s;
    logic             ir_valid_r,  ir_valid_s;
    logic             fetch_err_r, fetch_err_s;
    logic [31:0]      ir_err_s;

    // IR value loaded whenever ERR is entered.
`ifdef FETCH_ERR_NOP_EN
    assign ir_err_s = 32'h0000_0000;
`else
    assign ir_err_s = ir_r;
`endif

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        state_s     = state_r;
        ir_s        = ir_r;
        mem_addr_s  = mem_addr_r;
        cnt_s       = cnt_r;
        mem_req_s   = mem_req_r;
        busy_s      = busy_r;
        ir_valid_s  = ir_valid_r;
        fetch_err_s = fetch_err_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (fetch_start) begin
                    ir_valid_s = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned: no memory traffic at all.
                        state_s     = ST_ERR;
                        fetch_err_s = 1'b1;
                        mem_req_s   = 1'b0;
                        busy_s      = 1'b0;
                        ir_s        = ir_err_s;
                    end else begin
                        state_s     = ST_REQ;
                        mem_addr_s  = pc;
                        mem_req_s   = 1'b1;
                        busy_s      = 1'b1;
                        fetch_err_s = 1'b0;
                        cnt_s       = {CNT_W{1'b0}};
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    // Data on the final timeout cycle still wins over the error.
                    state_s    = ST_DONE;
                    ir_s       = mem_rdata;
                    mem_req_s  = 1'b0;
                    busy_s     = 1'b0;
                    ir_valid_s = 1'b1;
                end else if (TO_EN && (cnt_r == TO_LAST)) begin
                    state_s     = ST_ERR;
                    mem_req_s   = 1'b0;
                    busy_s      = 1'b0;
                    fetch_err_s = 1'b1;
                    ir_s        = ir_err_s;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                ir_s        = 32'h0000_0000;
                mem_addr_s  = 32'h0000_0000;
                cnt_s       = {CNT_W{1'b0}};
                mem_req_s   = 1'b0;
                busy_s      = 1'b0;
                ir_valid_s  = 1'b0;
                fetch_err_s = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ir_r        <= 32'h0000_0000;
            mem_addr_r  <= 32'h0000_0000;
            cnt_r       <= {CNT_W{1'b0}};
            mem_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            ir_valid_r  <= 1'b0;
            fetch_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ir_r        <= ir_s;
            mem_addr_r  <= mem_addr_s;
            cnt_r       <= cnt_s;
            mem_req_r   <= mem_req_s;
            busy_r      <= busy_s;
            ir_valid_r  <= ir_valid_s;
            fetch_err_r <= fetch_err_s;
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_req   = mem_req_r;
    assign busy      = busy_r;
    assign ir_valid  = ir_valid_r;
    assign fetch_err = fetch_err_r;
    assign instr     = ir_r;

    // Decoded fields are plain slices of IR.
    assign opcode   = ir_r[31:26];
    assign rs       = ir_r[25:21];
    assign rt       = ir_r[20:16];
    assign rd       = ir_r[15:11];
    assign shamt    = ir_r[10:6];
    assign funct    = ir_r[5:0];
    assign imm_16   = ir_r[15:0];
    assign j_target = ir_r[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed self-checking bench for instr_fetch_reg with an expected-IR scoreboard.
module tb_instr_fetch_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        ir_valid;
    logic        fetch_err;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm_16;
    logic [25:0] j_target;

    typedef struct {
        logic [31:0] ir;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_fetch_reg #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc(pc),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .ir_valid(ir_valid),
        .fetch_err(fetch_err), .instr(instr), .opcode(opcode), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm_16(imm_16),
        .j_target(j_target)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] ir, input logic err);
        exp_t e;
        e.ir  = ir;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_instr"}, instr, e.ir);
            chk({tag, "_err"}, {31'd0, fetch_err}, {31'd0, e.err});
            chk({tag, "_valid"}, {31'd0, ir_valid}, {31'd0, ~e.err});
        end
    endtask

    task automatic pulse(input logic [31:0] addr);
        pc          = addr;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    logic [31:0] ir_keep;
    int          req_cycles;

    initial begin
        rst_n       = 1'b0;
        fetch_start = 1'b0;
        pc          = 32'h0000_0000;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0000_0000;
        #2;
        chk("rst_ctrl", {28'd0, mem_req, busy, ir_valid, fetch_err}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_addr", mem_addr, 32'h0000_0000);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic fetch with mem_ready tied high.
        mem_ready = 1'b1;
        mem_rdata = 32'h2008_FFFC;
        sb_push(32'h2008_FFFC, 1'b0);
        pulse(32'h0000_0040);
        chk("f1_req", {31'd0, mem_req}, 32'd1);
        chk("f1_addr", mem_addr, 32'h0000_0040);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        chk("f1_valid_low", {31'd0, ir_valid}, 32'd0);
        tick();
        chk("f1_req_off", {31'd0, mem_req}, 32'd0);
        sb_pop("f1");
        chk("f1_opcode", {26'd0, opcode}, 32'h08);
        chk("f1_rt", {27'd0, rt}, 32'd8);
        chk("f1_imm", {16'd0, imm_16}, 32'h0000_FFFC);
        chk("f1_jt", {6'd0, j_target}, 32'h0008_FFFC);

        // Stall 3 cycles, then data on the 4th request cycle; stray fetch_start in REQ.
        mem_ready = 1'b0;
        mem_rdata = 32'h012A_4020;
        sb_push(32'h012A_4020, 1'b0);
        pulse(32'h0000_0080);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) req_cycles++;
            chk("st_addr", mem_addr, 32'h0000_0080);
            fetch_start = (i == 1);
            pc          = (i == 1) ? 32'h0000_0100 : 32'h0000_0080;
            mem_ready   = (i == 3);
            tick();
        end
        fetch_start = 1'b0;
        mem_ready   = 1'b0;
        chk("st_busy_cycles", req_cycles, 32'd4);
        chk("st_busy_off", {31'd0, busy}, 32'd0);
        chk("st_addr_final", mem_addr, 32'h0000_0080);
        sb_pop("st");
        chk("st_rs", {27'd0, rs}, 32'd9);
        chk("st_rt", {27'd0, rt}, 32'd10);
        chk("st_rd", {27'd0, rd}, 32'd8);
        chk("st_funct", {26'd0, funct}, 32'h20);
        tick();
        chk("st_hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("st_hold_instr", instr, 32'h012A_4020);

        // Misaligned address from DONE.
`ifdef FETCH_ERR_NOP_EN
        ir_keep = 32'h0000_0000;
`else
        ir_keep = 32'h012A_4020;
`endif
        mem_ready = 1'b1;
        sb_push(ir_keep, 1'b1);
        pulse(32'h0000_0042);
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        sb_pop("mis");
        tick();
        chk("mis_hold_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_no_req", {31'd0, mem_req}, 32'd0);

        // Timeout: mem_ready never arrives.
        mem_ready = 1'b0;
        sb_push(ir_keep, 1'b1);
        pulse(32'h0000_00C0);
        chk("to_err_clear", {31'd0, fetch_err}, 32'd0);
        req_cycles = 0;
        while (mem_req && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", req_cycles, 32'd4);
        sb_pop("to");
        chk("to_busy", {31'd0, busy}, 32'd0);

        // Recovery fetch from ERR.
        mem_ready = 1'b1;
        mem_rdata = 32'h8C22_0004;
        sb_push(32'h8C22_0004, 1'b0);
        pulse(32'h0000_0100);
        chk("rc_addr", mem_addr, 32'h0000_0100);
        tick();
        sb_pop("rc");
        chk("rc_opcode", {26'd0, opcode}, 32'h23);

        // Reset during REQ, late mem_ready must be ignored.
        mem_ready = 1'b0;
        pulse(32'h0000_0200);
        chk("rr_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("rr_ctrl", {28'd0, mem_req, busy, ir_valid, fetch_err}, 32'd0);
        chk("rr_instr", instr, 32'h0000_0000);
        chk("rr_addr", mem_addr, 32'h0000_0000);
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("rr_post_ctrl", {28'd0, mem_req, busy, ir_valid, fetch_err}, 32'd0);
        chk("rr_post_instr", instr, 32'h0000_0000);
        chk("rr_sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
- Instruction-fetch sequencer and Instruction Register (IR) for the multi-cycle MIPS datapath.
- On a fetch command from the control unit it issues one word read to instruction memory and latches the returned word into IR.
- It exposes the decoded instruction fields; imm_16 feeds the downstream sign extender directly.
- Sits between the control unit / instruction memory and the register file / immediate-extension stage.

Parameters:
- TIMEOUT, 16, number of cycles mem_req may stay unanswered before a fetch error is raised; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_start  input  1  single-cycle pulse from the control unit in the IF state
- pc  input  32  byte address to fetch; sampled on an accepted fetch_start
- mem_addr  output  32  address presented to instruction memory
- mem_req  output  1  read request, held until accepted
- mem_ready  input  1  memory accept/data-valid; a transfer completes when mem_req and mem_ready are both high at a rising edge
- mem_rdata  input  32  read data, valid when mem_ready is high
- busy  output  1  high in REQ state
- ir_valid  output  1  IR holds a successfully fetched word
- fetch_err  output  1  last fetch failed (misaligned address or timeout)
- instr  output  32  IR contents
- opcode  output  6  instr[31:26]
- rs  output  5  instr[25:21]
- rt  output  5  instr[20:16]
- rd  output  5  instr[15:11]
- shamt  output  5  instr[10:6]
- funct  output  6  instr[5:0]
- imm_16  output  16  instr[15:0]
- j_target  output  26  instr[25:0]

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, immediately, regardless of state):
  - state=IDLE, IR=32'h0, mem_addr=0, counter=0.
  - mem_req=0, busy=0, ir_valid=0, fetch_err=0.
  - A fetch in progress is abandoned; a mem_ready arriving after reset is ignored.
- States: IDLE, REQ, DONE, ERR. All outputs are registered; the field outputs are combinational slices of IR.
- IDLE/DONE/ERR, fetch_start=1:
  - If pc[1:0]!=0: next state ERR, fetch_err=1, ir_valid=0, no memory request, IR unchanged.
  - Otherwise: next state REQ, mem_addr<=pc, mem_req=1, busy=1, ir_valid=0, fetch_err=0, counter<=0.
- REQ:
  - mem_ready=1: IR<=mem_rdata, next state DONE, mem_req=0, busy=0, ir_valid=1.
  - mem_ready=0: counter increments. When TIMEOUT!=0 and counter reaches TIMEOUT-1 with mem_ready still low, next state ERR, mem_req=0, fetch_err=1.
  - mem_ready on that same final cycle wins: data is captured, no error.
  - fetch_start while in REQ is ignored; mem_addr stays stable for the whole request.
- DONE: ir_valid held high and IR stable until the next accepted fetch_start.
- ERR: fetch_err held high until the next accepted fetch_start.
- mem_ready outside REQ is ignored.
- Latency: fetch_start at edge N, mem_req high in cycle N+1. With mem_ready in that cycle, ir_valid=1 and the new IR is visible in cycle N+2. Minimum is 2 cycles; each stall cycle adds 1.
- Back-to-back: fetch_start in the same cycle as entry to DONE is legal. It is sampled in DONE on the following edge.

Optional Feature:
- Macro FETCH_ERR_NOP_EN.
- Defined: entering ERR loads IR with 32'h00000000 (sll $0,$0,0, a NOP), so the decoded fields are all zero while in ERR.
- Undefined: IR retains its previous contents on error.
- In both cases ir_valid=0 and fetch_err=1 in ERR.

Test Plan:
- Reset then fetch: pc=0x00000040 pulse, mem_ready tied high, mem_rdata=0x2008FFFC -> mem_req 1 cycle with mem_addr=0x40; 2 cycles after the pulse ir_valid=1, opcode=6'h08, rt=8, imm_16=0xFFFC.
- Stall: mem_ready low 3 cycles then high with mem_rdata=0x012A4020 -> busy 4 cycles, IR=0x012A4020, rs=9, rt=10, rd=8, funct=6'h20.
- Misaligned: pc=0x00000042 -> no mem_req, fetch_err=1 next cycle, IR unchanged (or 0 with FETCH_ERR_NOP_EN).
- Timeout: TIMEOUT=4, mem_ready never high -> mem_req high exactly 4 cycles, then ERR with fetch_err=1. Repeat with mem_ready on the 4th cycle -> DONE, no error.
- fetch_start pulsed in REQ with a different pc -> ignored, mem_addr unchanged.
- rst_n low during REQ, then mem_ready high after release -> all outputs 0, IR=0, no capture.
